// File: rtl/e203_sim_run_ctrl.sv
// e203_sim_run_ctrl
// Run controller for the E203 simulation / FPGA test harness. It loads the
// ITCM from a byte stream, keeps the core in reset while loading, releases it,
// counts cycles and retired instructions, watches for tohost stores, runs a
// watchdog and reports pass/fail from x3. It also divides clk down to lfextclk.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle pulse that starts (or restarts) a run
//   ld_valid/ld_ready     byte-stream handshake; ld_byte data, ld_last = final byte
//   itcm_we/addr/wdata/wem  one-cycle ITCM word write (byte k in bits [8k+7:8k])
//   load_ovf              sticky: the image was larger than the ITCM
//   core_rst_n            SoC reset, held low until the image is loaded
//   lfextclk              clk / 2^(LFDIV_BIT+1)
//   cmt_valid, cmt_pc     ALU commit, compared against TOHOST_PC
//   ir_valid, ir_ready    EXU issue handshake (retired-instruction count)
//   x3                    regfile x3, sampled when the run completes
//   done/pass/timeout     run result
//   cycle_count, instr_count, end_cycle, tohost_cnt  run statistics
module e203_sim_run_ctrl #(
  parameter int              ITCM_AW     = 16,
  parameter int              PC_W        = 32,
  parameter logic [PC_W-1:0] TOHOST_PC   = 32'h80000086,
  parameter int              TOHOST_HITS = 8,
  parameter int              WDOG_BIT    = 20,
  parameter int              LFDIV_BIT   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [7:0]         ld_byte,
  input  logic               ld_last,
  output logic               itcm_we,
  output logic [ITCM_AW-1:0] itcm_addr,
  output logic [63:0]        itcm_wdata,
  output logic [7:0]         itcm_wem,
  output logic               load_ovf,
  output logic               core_rst_n,
  output logic               lfextclk,
  input  logic               cmt_valid,
  input  logic [PC_W-1:0]    cmt_pc,
  input  logic               ir_valid,
  input  logic               ir_ready,
  input  logic [31:0]        x3,
  output logic               done,
  output logic               pass,
  output logic               timeout,
  output logic [31:0]        cycle_count,
  output logic [31:0]        instr_count,
  output logic [31:0]        end_cycle,
  output logic [31:0]        tohost_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FLUSH, S_RUN, S_DONE, S_TOUT
  } state_t;

  state_t state_q, state_d;

  // Word assembly buffer, separate from the write register so bytes can
  // stream in at one per cycle while the previous word is being written.
  logic [2:0]         lane_q;
  logic [63:0]        asm_data_q;
  logic [7:0]         asm_mask_q;
  logic [ITCM_AW-1:0] waddr_q;
  logic               full_q;      // last ITCM word has been written
  logic               first_hit_q; // first tohost commit already seen
  logic [LFDIV_BIT:0] div_q;

  logic        accept;
  logic        word_done;
  logic [63:0] merged_data;
  logic [7:0]  merged_mask;
  logic        tohost_hit;
  logic        last_hit;
  logic        wdog_fire;

  assign accept      = ld_valid & ld_ready;
  assign word_done   = accept & ((lane_q == 3'd7) | ld_last);
  assign merged_data = asm_data_q | (64'(ld_byte) << {lane_q, 3'b000});
  assign merged_mask = asm_mask_q | (8'b1 << lane_q);
  assign tohost_hit  = cmt_valid & (cmt_pc == TOHOST_PC);
  assign last_hit    = tohost_hit & (tohost_cnt == 32'(TOHOST_HITS - 1));
  assign wdog_fire   = cycle_count[WDOG_BIT];
  assign lfextclk    = div_q[LFDIV_BIT];

  // NOTE: every signal written in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d  = state_q;
    ld_ready = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD: begin
        ld_ready = 1'b1;
        if (accept && ld_last) state_d = S_FLUSH;
      end
      S_FLUSH: state_d = S_RUN;
      S_RUN: begin
        // A completing hit takes priority over the watchdog.
        if (last_hit)       state_d = S_DONE;
        else if (wdog_fire) state_d = S_TOUT;
      end
      S_DONE, S_TOUT: if (start) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Free-running divider, independent of the run state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_q + (LFDIV_BIT+1)'(1);
  end

  // NOTE: the assembly data is reset and cleared after each word along with
  // its mask, because bytes are OR-merged in and unfilled lanes must read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q      <= '0;
      asm_data_q  <= '0;
      asm_mask_q  <= '0;
      waddr_q     <= '0;
      full_q      <= 1'b0;
      first_hit_q <= 1'b0;
      itcm_we     <= 1'b0;
      itcm_addr   <= '0;
      itcm_wdata  <= '0;
      itcm_wem    <= '0;
      load_ovf    <= 1'b0;
      core_rst_n  <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      instr_count <= '0;
      end_cycle   <= '0;
      tohost_cnt  <= '0;
    end else begin
      itcm_we <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_TOUT: begin
          if (start) begin
            lane_q      <= '0;
            asm_data_q  <= '0;
            asm_mask_q  <= '0;
            waddr_q     <= '0;
            full_q      <= 1'b0;
            first_hit_q <= 1'b0;
            load_ovf    <= 1'b0;
            core_rst_n  <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            instr_count <= '0;
            end_cycle   <= '0;
            tohost_cnt  <= '0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (full_q) begin
              // Past the end of the ITCM: accept and drop, no address wrap.
              load_ovf <= 1'b1;
            end else if (word_done) begin
              itcm_we    <= 1'b1;
              itcm_addr  <= waddr_q;
              itcm_wdata <= merged_data;
              itcm_wem   <= merged_mask;
              lane_q     <= '0;
              asm_data_q <= '0;
              asm_mask_q <= '0;
              if (&waddr_q) full_q  <= 1'b1;
              else          waddr_q <= waddr_q + ITCM_AW'(1);
            end else begin
              asm_data_q <= merged_data;
              asm_mask_q <= merged_mask;
              lane_q     <= lane_q + 3'd1;
            end
          end
        end
        S_FLUSH: core_rst_n <= 1'b1;
        S_RUN: begin
          cycle_count <= cycle_count + 32'd1;
          if (ir_valid && ir_ready && !first_hit_q)
            instr_count <= instr_count + 32'd1;
          if (tohost_hit) begin
            tohost_cnt <= tohost_cnt + 32'd1;
            if (!first_hit_q) begin
              end_cycle   <= cycle_count;
              first_hit_q <= 1'b1;
            end
          end
          if (last_hit) begin
            done <= 1'b1;
            pass <= (x3 == 32'd1);
          end else if (wdog_fire) begin
            done    <= 1'b1;
            timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/e203_sim_run_ctrl.md
Name: e203_sim_run_ctrl

Overview:
- Synthesizable run controller for the E203 SoC simulation and FPGA test harness.
- Sequences a whole test run in order:
  - preloads the ITCM from a byte stream, packing bytes into 64-bit words;
  - holds the core in reset during the load, then releases it;
  - monitors the commit PC for tohost writes and counts cycles and retired instructions;
  - runs a watchdog;
  - reports pass/fail from x3.
- Also generates the low-frequency clock (lfextclk) for the SoC.
- Sits between the harness top and the SoC instance; replaces ad-hoc initial blocks and hierarchical pokes.

Parameters:
- ITCM_AW, 16, ITCM word-address width (64-bit words).
- PC_W, 32, commit PC width.
- TOHOST_PC, 32'h80000086, PC of the tohost store instruction.
- TOHOST_HITS, 8, number of tohost commits that ends the test.
- WDOG_BIT, 20, cycle_count bit whose assertion means timeout.
- LFDIV_BIT, 5, free-running divider bit driven onto lfextclk.

Ports:
- clk  in  1  core/harness clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins load
- ld_valid  in  1  loader byte valid
- ld_ready  out  1  loader byte ready
- ld_byte  in  8  byte data, sent in ascending address order from 0
- ld_last  in  1  marks the final byte of the image
- itcm_we  out  1  ITCM write strobe
- itcm_addr  out  ITCM_AW  ITCM word address
- itcm_wdata  out  64  write data; byte k sits in bits [8k+7:8k]
- itcm_wem  out  8  per-byte write enable
- load_ovf  out  1  sticky: image exceeded the ITCM size
- core_rst_n  out  1  SoC reset, active low
- lfextclk  out  1  divided clock
- cmt_valid  in  1  ALU commit valid
- cmt_pc  in  PC_W  ALU commit PC
- ir_valid  in  1  EXU i_valid
- ir_ready  in  1  EXU i_ready
- x3  in  32  regfile x3 value
- done  out  1  test finished (pass, fail or timeout)
- pass  out  1  x3==1 at completion
- timeout  out  1  watchdog fired
- cycle_count  out  32  RUN cycles elapsed
- instr_count  out  32  handshakes before the first tohost commit
- end_cycle  out  32  cycle_count value at the first tohost commit
- tohost_cnt  out  32  number of tohost commits

Behaviour:
- Clock and reset: one clock (clk). Reset (rst_n) is asynchronous, active-low.
- Reset values:
  - state = IDLE.
  - All outputs are 0, including core_rst_n = 0 and ld_ready = 0.
  - Divider is 0.
- lfextclk: a 6-bit (LFDIV_BIT+1) divider increments every cycle from reset, independent of state. lfextclk = divider[LFDIV_BIT], i.e. period 64 clk.
- States: IDLE, LOAD, FLUSH, RUN, DONE, TOUT.
- IDLE:
  - start -> LOAD.
  - On entry to LOAD: counters, flags, byte lane and word address clear; core_rst_n = 0.
- LOAD:
  - ld_ready = 1. A byte is accepted on ld_valid & ld_ready.
  - The byte goes into assembly lane = lane counter (0..7); the lane's mask bit is set.
  - The word is complete when lane 7 is accepted or ld_last is accepted. On the next cycle:
    - itcm_we = 1 for exactly one cycle;
    - itcm_addr = current word address;
    - itcm_wdata = assembled data (unfilled lanes are 0);
    - itcm_wem = filled-lane mask.
  - Then the word address increments, the lane resets to 0 and the mask clears.
  - Bytes can be accepted back-to-back at one per cycle; the write register is separate from the assembly buffer.
  - Overflow: bytes arriving after word 2^ITCM_AW-1 has been written are accepted and dropped, with no write and no address wrap. load_ovf is set and stays set until the next start.
  - ld_last accepted -> FLUSH.
- FLUSH:
  - Exactly one cycle; the final write is issued here if pending.
  - ld_ready = 0.
  - -> RUN.
- RUN:
  - core_rst_n = 1 from the first RUN cycle onward.
  - cycle_count starts at 0 and increments every RUN cycle.
  - Tohost hit = cmt_valid & (cmt_pc == TOHOST_PC). Each hit increments tohost_cnt.
  - First hit (flag clear): end_cycle <= cycle_count, and the flag is set.
  - instr_count increments on ir_valid & ir_ready while the flag is clear. The handshake in the first-hit cycle counts.
  - DONE transition: a hit that makes tohost_cnt reach TOHOST_HITS goes to DONE on that edge, with done = 1 and pass = (x3 == 1) sampled in the same cycle.
  - TOUT transition: cycle_count[WDOG_BIT] == 1 goes to TOUT with done = 1, timeout = 1, pass = 0.
  - If both conditions hold in the same cycle, DONE wins.
- DONE / TOUT:
  - All counters and status outputs are frozen; core_rst_n stays 1.
  - start -> LOAD (full restart, core back in reset).
- start is ignored in LOAD, FLUSH and RUN.
- Reset mid-operation: immediate return to reset values. Any partially assembled word is discarded and no write is issued.

Test Plan:
- Load an 8-byte image 11..18 with ld_last on byte 8 -> one write: addr 0, wdata 0x1817161514131211, wem 0xFF. core_rst_n rises 2 cycles after ld_last is accepted.
- Load a 13-byte image -> two writes: addr 0 with wem 0xFF, then addr 1 with wem 0x1F and upper 3 bytes 0.
- In RUN, drive 8 commits with cmt_pc = 0x80000086, first at cycle_count 100, and x3 = 1 -> done = 1, pass = 1, end_cycle = 100, tohost_cnt = 8. 7 hits only -> done stays 0.
- Same run with x3 = 3 -> done = 1, pass = 0, timeout = 0.
- No tohost commit -> at cycle_count = 2^20: timeout = 1, done = 1, pass = 0, counters frozen. 8th hit in that same cycle -> DONE and pass per x3.
- ITCM_AW = 2 with a 40-byte image -> 4 writes, load_ovf = 1. Toggle rst_n low mid-load -> itcm_we = 0, core_rst_n = 0, state IDLE. Verify lfextclk period = 64 clk.
